// File: rtl/vcve2_vrf_agu.sv
// Vector register file address generator: walks the words of the vs1/vs2/vd
// register groups in data memory for one vector operation.
module vcve2_vrf_agu #(
    parameter int unsigned VLEN     = 128,
    parameter logic [31:0] VRF_BASE = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        get_rs1_i,
    input  logic        get_rs2_i,
    input  logic        get_rd_i,
    input  logic        incr_i,
    input  logic [4:0]  vs1_i,
    input  logic [4:0]  vs2_i,
    input  logic [4:0]  vd_i,
    input  logic [2:0]  lmul_i,
    input  logic [1:0]  sew_i,
    input  logic [31:0] vl_i,
    output logic [31:0] addr_o,
    output logic        busy_o,
    output logic        last_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned WPR = VLEN / 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_base_rs1;
    logic [31:0] r_base_rs2;
    logic [31:0] r_base_rd;
    logic [31:0] r_offset;
    logic [31:0] r_nwords;
    logic        r_err;

    logic [3:0]  w_lmul;
    logic [3:0]  w_mask;
    logic [1:0]  w_sew_shift;
    logic [34:0] w_bytes;
    logic [34:0] w_words_raw;
    logic [34:0] w_cap;
    logic [31:0] w_nwords;
    logic        w_misalign;
    logic        w_at_last;
    logic [31:0] w_base_sel;

    function automatic logic [31:0] f_base(input logic [4:0] x);
        return VRF_BASE + ({27'b0, x} * 32'(WPR * 4));
    endfunction

    // Operand decode; length is kept at 35 bits so huge vl never wraps before the clamp.
    always_comb begin
        w_lmul = 4'd1;
        case (lmul_i)
            3'd1:    w_lmul = 4'd2;
            3'd2:    w_lmul = 4'd4;
            3'd3:    w_lmul = 4'd8;
            default: w_lmul = 4'd1;
        endcase
        w_sew_shift = 2'd2;
        case (sew_i)
            2'd0:    w_sew_shift = 2'd0;
            2'd1:    w_sew_shift = 2'd1;
            default: w_sew_shift = 2'd2;
        endcase
        w_bytes     = {3'b0, vl_i} << w_sew_shift;
        w_words_raw = (w_bytes + 35'd3) >> 2;
        w_cap       = 35'(WPR) * {31'b0, w_lmul};
        w_nwords    = (w_words_raw < w_cap) ? w_words_raw[31:0] : w_cap[31:0];
        w_mask      = w_lmul - 4'd1;
        w_misalign  = |(vs1_i[3:0] & w_mask) | |(vs2_i[3:0] & w_mask)
                    | |(vd_i[3:0] & w_mask);
    end

    assign w_at_last = (r_offset == r_nwords - 32'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        last_o      = 1'b0;
        done_o      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
            end
            ST_ACTIVE: begin
                busy_o = 1'b1;
                last_o = w_at_last;
                if (incr_i && w_at_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A new load restarts from any state, overriding a pending advance.
        if (load_i) begin
            w_state_nxt = (w_nwords != 32'd0) ? ST_ACTIVE : ST_DONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base_rs1 <= '0;
            r_base_rs2 <= '0;
            r_base_rd  <= '0;
            r_offset   <= '0;
            r_nwords   <= '0;
            r_err      <= 1'b0;
        end else if (load_i) begin
            r_base_rs1 <= f_base(vs1_i);
            r_base_rs2 <= f_base(vs2_i);
            r_base_rd  <= f_base(vd_i);
            r_offset   <= '0;
            r_nwords   <= w_nwords;
            r_err      <= w_misalign;
        end else if (r_state == ST_ACTIVE && incr_i && !w_at_last) begin
            r_offset <= r_offset + 32'd1;
        end
    end

    always_comb begin
        if (get_rd_i) begin
            w_base_sel = r_base_rd;
        end else if (get_rs2_i) begin
            w_base_sel = r_base_rs2;
        end else begin
            w_base_sel = r_base_rs1;
        end
    end

    assign addr_o = w_base_sel + (r_offset << 2);
    assign err_o  = r_err;

endmodule

// File: tb/tb_vcve2_vrf_agu.sv
// Scoreboard bench for vcve2_vrf_agu: per-cycle expected outputs from an
// arithmetic reference model are queued and checked by an independent monitor.
module tb_vcve2_vrf_agu;

    localparam int unsigned VLEN     = 128;
    localparam logic [31:0] VRF_BASE = 32'h0000_1000;
    localparam int unsigned WPR      = VLEN / 32;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        load_i = 1'b0;
    logic        get_rs1_i = 1'b0;
    logic        get_rs2_i = 1'b0;
    logic        get_rd_i = 1'b0;
    logic        incr_i = 1'b0;
    logic [4:0]  vs1_i = '0;
    logic [4:0]  vs2_i = '0;
    logic [4:0]  vd_i = '0;
    logic [2:0]  lmul_i = '0;
    logic [1:0]  sew_i = '0;
    logic [31:0] vl_i = '0;
    logic [31:0] addr_o;
    logic        busy_o;
    logic        last_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    vcve2_vrf_agu #(
        .VLEN     (VLEN),
        .VRF_BASE (VRF_BASE)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .load_i    (load_i),
        .get_rs1_i (get_rs1_i),
        .get_rs2_i (get_rs2_i),
        .get_rd_i  (get_rd_i),
        .incr_i    (incr_i),
        .vs1_i     (vs1_i),
        .vs2_i     (vs2_i),
        .vd_i      (vd_i),
        .lmul_i    (lmul_i),
        .sew_i     (sew_i),
        .vl_i      (vl_i),
        .addr_o    (addr_o),
        .busy_o    (busy_o),
        .last_o    (last_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        busy;
        logic        last;
        logic        done;
        logic        err;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: "which word of how many", plus the three register bases.
    bit          m_busy;
    bit          m_done;
    bit          m_err;
    longint      m_idx;
    longint      m_nw;
    bit [31:0]   m_b1;
    bit [31:0]   m_b2;
    bit [31:0]   m_bd;

    function automatic bit [31:0] ref_base(input int x);
        return VRF_BASE + 32'(x * 4 * WPR);
    endfunction

    task automatic model_clear();
        m_busy = 0; m_done = 0; m_err = 0; m_idx = 0; m_nw = 0;
        m_b1 = 0; m_b2 = 0; m_bd = 0;
    endtask

    task automatic model_tick();
        longint lm, sb, need, cap, vl64;
        if (load_i) begin
            lm   = (lmul_i <= 3) ? (longint'(1) << lmul_i) : 1;
            sb   = (sew_i == 0) ? 1 : (sew_i == 1) ? 2 : 4;
            vl64 = longint'({32'b0, vl_i});
            need = (vl64 * sb + 3) / 4;
            cap  = WPR * lm;
            m_nw   = (need < cap) ? need : cap;
            m_idx  = 0;
            m_busy = (m_nw > 0);
            m_done = (m_nw == 0);
            m_err  = ((vs1_i % lm) != 0) || ((vs2_i % lm) != 0) || ((vd_i % lm) != 0);
            m_b1 = ref_base(int'(vs1_i));
            m_b2 = ref_base(int'(vs2_i));
            m_bd = ref_base(int'(vd_i));
        end else if (m_busy && incr_i) begin
            if (m_idx == m_nw - 1) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_idx++;
            end
        end else begin
            m_done = 0;
        end
    endtask

    function automatic obs_t expect_now();
        obs_t      e;
        bit [31:0] b;
        b = get_rd_i ? m_bd : (get_rs2_i ? m_b2 : m_b1);
        e.addr = b + 32'(m_idx * 4);
        e.busy = m_busy;
        e.last = m_busy && (m_idx == m_nw - 1);
        e.done = m_done;
        e.err  = m_err;
        return e;
    endfunction

    task automatic drive(input bit ld, input bit [2:0] sel, input bit inc);
        @(posedge clk); #1;
        model_tick();
        load_i = ld;
        {get_rd_i, get_rs2_i, get_rs1_i} = sel;
        incr_i = inc;
        exp_q.push_back(expect_now());
    endtask

    task automatic load_op(input int a, input int b, input int d, input int lm,
                           input int sw, input bit [31:0] vl, input bit [2:0] sel,
                           input bit inc);
        @(posedge clk); #1;
        model_tick();
        vs1_i = 5'(a); vs2_i = 5'(b); vd_i = 5'(d);
        lmul_i = 3'(lm); sew_i = 2'(sw); vl_i = vl;
        load_i = 1'b1;
        {get_rd_i, get_rs2_i, get_rs1_i} = sel;
        incr_i = inc;
        exp_q.push_back(expect_now());
    endtask

    // Reset is asserted and released between clock edges to expose its asynchronous effect.
    task automatic pulse_reset();
        @(posedge clk); #1;
        model_tick();
        rst_ni = 1'b0;
        load_i = 1'b0; incr_i = 1'b0;
        {get_rd_i, get_rs2_i, get_rs1_i} = 3'b000;
        model_clear();
        exp_q.push_back(expect_now());
        #6 rst_ni = 1'b1;
    endtask

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {addr_o, busy_o, last_o, done_o, err_o};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t: got addr=%h busy=%b last=%b done=%b err=%b, expected addr=%h busy=%b last=%b done=%b err=%b",
                             $time, a.addr, a.busy, a.last, a.done, a.err,
                             e.addr, e.busy, e.last, e.done, e.err);
                end
            end
        end
    end

    initial begin
        bit [31:0] rvl;
        model_clear();
        exp_q.push_back(expect_now());
        #12 rst_ni = 1'b1;

        // incr in idle must not move the offset
        drive(0, 3'b001, 1);
        drive(0, 3'b100, 1);

        // basic m1 run: rs1 0x1020.., rd 0x1060..
        load_op(2, 4, 6, 0, 2, 32'd4, 3'b001, 0);
        drive(0, 3'b001, 0);
        for (int i = 0; i < 4; i++) drive(0, (i % 2 == 0) ? 3'b001 : 3'b100, 1);
        drive(0, 3'b100, 0);
        drive(0, 3'b001, 1);

        // rounding (8b x5 -> 2 words) and clamping (m2, 100 words -> 8)
        load_op(1, 1, 1, 0, 0, 32'd5, 3'b010, 0);
        for (int i = 0; i < 4; i++) drive(0, 3'b010, 1);
        load_op(0, 2, 8, 1, 2, 32'd100, 3'b100, 0);
        for (int i = 0; i < 10; i++) drive(0, 3'b100, 1);

        // zero length and misalignment
        load_op(0, 0, 0, 0, 2, 32'd0, 3'b001, 0);
        drive(0, 3'b001, 1);
        drive(0, 3'b001, 0);
        load_op(0, 3, 4, 2, 2, 32'd8, 3'b010, 0);
        for (int i = 0; i < 10; i++) drive(0, 3'b010, (i % 3) != 0);
        load_op(4, 8, 12, 2, 2, 32'd2, 3'b001, 0);
        drive(0, 3'b001, 1);
        drive(0, 3'b001, 1);

        // restart with load+incr at offset 2
        load_op(2, 4, 6, 0, 2, 32'd4, 3'b001, 0);
        drive(0, 3'b001, 1);
        drive(0, 3'b001, 1);
        load_op(8, 12, 16, 0, 2, 32'd4, 3'b010, 1);
        for (int i = 0; i < 6; i++) drive(0, 3'b010, 1);

        // reset at offset 3 of 4, then incr in idle
        load_op(2, 4, 6, 0, 2, 32'd4, 3'b001, 0);
        for (int i = 0; i < 3; i++) drive(0, 3'b001, 1);
        pulse_reset();
        for (int i = 0; i < 3; i++) drive(0, 3'b001, 1);

        // maximum length must clamp without wrapping
        load_op(0, 0, 8, 3, 2, 32'hFFFF_FFFF, 3'b100, 0);
        for (int i = 0; i < 40; i++) drive(0, 3'b100, 1);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rvl = 32'd0;
                    1:       rvl = 32'($urandom_range(1, 40));
                    2:       rvl = $urandom;
                    default: rvl = 32'hFFFF_FFFF;
                endcase
                load_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 3)), rvl, 3'($urandom_range(0, 7)),
                        $urandom_range(0, 1) == 1);
            end else begin
                drive(0, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
            end
        end

        drive(0, 3'b000, 0);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vcve2_vrf_agu.md
VCVE2_VRF_AGU -- requirements
Module: vcve2_vrf_agu

Interface
REQ-001 SHALL have parameter VLEN, default 128: vector register length in bits, a multiple of 32.
REQ-002 SHALL have parameter VRF_BASE, default 32'h0000_1000: byte address of v0 word 0 in data memory.
REQ-003 SHALL define WPR = VLEN/32 (words per register), derived and not overridable.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_i  input  1  start a new vector operation and capture operands.
REQ-007 SHALL have port get_rs1_i / get_rs2_i / get_rd_i  input  1 each  select which address is driven on addr_o.
REQ-008 SHALL have port incr_i  input  1  advance to the next word.
REQ-009 SHALL have ports vs1_i / vs2_i / vd_i  input  5 each  register indices, sampled on load_i.
REQ-010 SHALL have port lmul_i  input  3  LMUL encoding, sampled on load_i: 0=m1, 1=m2, 2=m4, 3=m8; any other value is treated as m1.
REQ-011 SHALL have port sew_i  input  2  SEW encoding, sampled on load_i: 0=8b, 1=16b, 2=32b; 3 is treated as 32b.
REQ-012 SHALL have port vl_i  input  32  vector length in elements, sampled on load_i.
REQ-013 SHALL have port addr_o  output  32  word-aligned byte address.
REQ-014 SHALL have port busy_o  output  1  high while in ACTIVE state.
REQ-015 SHALL have port last_o  output  1  the current word is the final word of the operation.
REQ-016 SHALL have port done_o  output  1  single-cycle pulse on completion.
REQ-017 SHALL have port err_o  output  1  register index misaligned to the LMUL group; sticky until the next load_i.

Function
REQ-018 SHALL implement FSM states IDLE, ACTIVE and DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-019 On load_i, the block SHALL register base_x = VRF_BASE + x*WPR*4 for x in {vs1, vs2, vd}, using 32-bit modulo arithmetic.
REQ-020 On load_i, the block SHALL register nwords = min(ceil(vl*SEWbytes/4), WPR*LMUL), computed with an intermediate of at least 35 bits and no truncation before the clamp.
REQ-021 On load_i, the offset counter SHALL be cleared to 0.
REQ-022 After load_i, the next state SHALL be ACTIVE if nwords > 0, otherwise DONE.
REQ-023 err_o SHALL be set at load_i if any of vs1, vs2 or vd modulo LMUL is nonzero; the FSM SHALL still proceed.
REQ-024 addr_o SHALL be a combinational function of the registered state: base_sel + offset*4.
REQ-025 addr_o source selection SHALL use priority get_rd_i > get_rs2_i > get_rs1_i, and SHALL be base_rs1 + offset*4 when no select is high.
REQ-026 In ACTIVE, incr_i SHALL increment offset by 1.
REQ-027 When offset == nwords-1 and incr_i is high, the next state SHALL be DONE and offset SHALL hold its value.
REQ-028 last_o SHALL equal (state==ACTIVE && offset==nwords-1).
REQ-029 done_o SHALL be 1 exactly in the DONE state.
REQ-030 In IDLE or DONE, incr_i SHALL be ignored.
REQ-031 If load_i and incr_i are high in the same cycle, load_i SHALL take priority, restarting at offset 0 from any state, including mid-ACTIVE.
REQ-032 busy_o SHALL equal (state==ACTIVE).
REQ-033 Latency: busy_o SHALL rise one cycle after load_i, and done_o SHALL pulse one cycle after the final incr_i.

Reset
REQ-034 Asserting rst_ni low SHALL immediately force state=IDLE, offset=0, nwords=0, all bases=0 and err_o=0; this applies even mid-operation.
REQ-035 During reset, the outputs SHALL be busy_o=0, last_o=0, done_o=0, err_o=0 and addr_o=0.
REQ-036 After reset release, no activity SHALL occur until load_i.

Verification
REQ-037 Basic m1 run: VLEN=128, load vs1=2, vs2=4, vd=6, lmul=0, sew=2, vl=4 -> nwords=4; rs1 addresses 0x1020, 0x1024, 0x1028, 0x102C; rd addresses 0x1060..0x106C; last_o on the 4th word; done_o one cycle after the 4th incr_i.
REQ-038 Clamping and rounding: sew=0, vl=5 -> nwords=2; lmul=1, sew=2, vl=100 -> nwords clamped to 8 and vd=8 gives rd addresses 0x1080..0x109C.
REQ-039 Zero length and misalignment: vl=0 -> done_o pulses the cycle after load_i with busy_o never high; lmul=2 with vs2=3 -> err_o=1 until the next load_i.
REQ-040 Restart: load_i together with incr_i at offset 2 -> offset 0 with the new bases, and no done_o pulse for the aborted run.
REQ-041 Reset and idle behaviour: asynchronous reset at offset 3 of 4 -> all outputs 0 immediately and no done_o after release; incr_i in IDLE -> offset stays 0.
